// File: rtl/vector_issue_queue_if.sv
// vector_issue_queue_if: dispatch/issue bundle between scalar core, issue queue and vector scoreboard.
interface vector_issue_queue_if #(
    parameter int DEPTH            = 4,
    parameter int DATA_FROM_SCALAR = 96,
    parameter int INSTRUCTION_BITS = 32
);
    logic                                valid_in;
    logic [DATA_FROM_SCALAR-1:0]         data_in;
    logic                                ready_out;
    logic                                flush;
    logic                                valid_fifo;
    logic [DATA_FROM_SCALAR-1:0]         instruction_to_issue;
    logic                                pop_data;
    logic [$clog2(DEPTH+1)-1:0]          occupancy;
    logic                                overflow_err;
    logic                                underflow_err;
    logic [INSTRUCTION_BITS-1:0]         head_instruction;
    // Instruction field of the head packet, for the scoreboard decoder.
    assign head_instruction = instruction_to_issue[DATA_FROM_SCALAR-1 -: INSTRUCTION_BITS];
    modport master (
        output valid_in, data_in, flush, pop_data,
        input  ready_out, valid_fifo, instruction_to_issue, occupancy,
               overflow_err, underflow_err, head_instruction
    );
    modport slave (
        input  valid_in, data_in, flush, pop_data,
        output ready_out, valid_fifo, instruction_to_issue, occupancy,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/vector_issue_queue.sv
// vector_issue_queue: circular buffer of scalar dispatch packets feeding the vector scoreboard.
// Define VIQ_BYPASS_EN to forward a packet pushed into an empty queue to the head in the same cycle.
module vector_issue_queue #(
    parameter int DEPTH            = 4,
    parameter int DATA_FROM_SCALAR = 96
) (
    input logic                clk,
    input logic                rst_n,
    vector_issue_queue_if.slave q
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic empty, push, wr_en, rd_en;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty       = occ == '0;
    assign q.ready_out = occ != OW'(DEPTH);
    assign q.occupancy = occ;
    assign push        = q.valid_in & q.ready_out;
    assign rd_en       = q.pop_data & ~empty;
`ifdef VIQ_BYPASS_EN
    // An empty-queue push that is popped in the same cycle never touches storage.
    assign q.valid_fifo           = ~empty | q.valid_in;
    assign q.instruction_to_issue = ~empty ? mem[rd_ptr] : q.valid_in ? q.data_in : '0;
    assign wr_en                  = push & ~(empty & q.pop_data);
`else
    assign q.valid_fifo           = ~empty;
    assign q.instruction_to_issue = empty ? '0 : mem[rd_ptr];
    assign wr_en                  = push;
`endif
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= q.data_in;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            q.overflow_err  <= 1'b0;
            q.underflow_err <= 1'b0;
        end else begin
            if (q.valid_in & ~q.ready_out) q.overflow_err <= 1'b1;
            if (q.pop_data & ~q.valid_fifo) q.underflow_err <= 1'b1;
            if (q.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (wr_en) wr_ptr <= nxt(wr_ptr);
                if (rd_en) rd_ptr <= nxt(rd_ptr);
                occ <= occ + OW'(wr_en) - OW'(rd_en);
            end
        end
    end
endmodule

// File: tb/tb_vector_issue_queue.sv
// tb_vector_issue_queue: directed plus random stimulus on DEPTH=4 and DEPTH=3 queues against a queue-based model.
module tb_vector_issue_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
`ifdef VIQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic v_i = 1'b0, p_i = 1'b0, f_i = 1'b0;
    logic [95:0] d_i = '0;
    vector_issue_queue_if #(.DEPTH(4)) a();
    vector_issue_queue_if #(.DEPTH(3)) b();
    assign a.valid_in = v_i;
    assign a.data_in  = d_i;
    assign a.pop_data = p_i;
    assign a.flush    = f_i;
    assign b.valid_in = v_i;
    assign b.data_in  = d_i;
    assign b.pop_data = p_i;
    assign b.flush    = f_i;
    vector_issue_queue #(.DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .q(a));
    vector_issue_queue #(.DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .q(b));
    int n_chk = 0;
    int n_fail = 0;
    int dep [2] = '{4, 3};
    logic [95:0] mq [2][$];
    bit ovf [2];
    bit unf [2];
    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction
    task automatic chk(input string tag, input int i, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s depth%0d: observed %h expected %h", tag, dep[i], obs, exp);
        end
    endtask
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int sz = mq[i].size();
            bit em = sz == 0;
            bit ev = !em || (BYP && v_i);
            logic [95:0] eh = !em ? mq[i][0] : (BYP && v_i) ? d_i : 96'd0;
            chk("occupancy", i, i == 0 ? 96'(a.occupancy) : 96'(b.occupancy), 96'(sz));
            chk("ready_out", i, i == 0 ? 96'(a.ready_out) : 96'(b.ready_out), 96'(sz != dep[i]));
            chk("valid_fifo", i, i == 0 ? 96'(a.valid_fifo) : 96'(b.valid_fifo), 96'(ev));
            chk("head", i, i == 0 ? a.instruction_to_issue : b.instruction_to_issue, eh);
            chk("overflow_err", i, i == 0 ? 96'(a.overflow_err) : 96'(b.overflow_err), 96'(ovf[i]));
            chk("underflow_err", i, i == 0 ? 96'(a.underflow_err) : 96'(b.underflow_err), 96'(unf[i]));
        end
    endtask
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit em = mq[i].size() == 0;
            bit fu = mq[i].size() == dep[i];
            bit ev = !em || (BYP && v_i);
            bit push = v_i && !fu;
            bit pop = p_i && ev;
            if (v_i && fu) ovf[i] = 1'b1;
            if (p_i && !ev) unf[i] = 1'b1;
            if (f_i) mq[i].delete();
            else if (!(em && push && pop)) begin
                if (pop) void'(mq[i].pop_front());
                if (push) mq[i].push_back(d_i);
            end
        end
    endtask
    task automatic step(input logic v, input logic [95:0] d, input logic p, input logic f);
        v_i = v; d_i = d; p_i = p; f_i = f;
        #1 check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask
    initial begin
        #12 check_all();
        @(negedge clk) rst_n = 1'b1;
        // Fill: A..D, then pop on full with a rejected E.
        step(1'b1, {32'hA000_0001, 64'h1111}, 1'b0, 1'b0);
        step(1'b1, {32'hB000_0002, 64'h2222}, 1'b0, 1'b0);
        step(1'b1, {32'hC000_0003, 64'h3333}, 1'b0, 1'b0);
        step(1'b1, {32'hD000_0004, 64'h4444}, 1'b0, 1'b0);
        step(1'b1, {32'hE000_0005, 64'h5555}, 1'b1, 1'b0);
        idle();
        for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        // Steady stream at occupancy 2, wrapping both pointer sets.
        step(1'b1, rnd96(), 1'b0, 1'b0);
        step(1'b1, rnd96(), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, rnd96(), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
        // Flush with a same-cycle push.
        for (int k = 0; k < 3; k++) step(1'b1, rnd96(), 1'b0, 1'b0);
        step(1'b1, {32'hDEAD_BEEF, 64'h77}, 1'b0, 1'b1);
        idle();
        idle();
        // Push into empty queue with and without a same-cycle pop.
        step(1'b1, {32'hF000_0006, 64'h6666}, 1'b1, 1'b0);
        idle();
        step(1'b1, {32'hF000_0007, 64'h7777}, 1'b0, 1'b0);
        idle();
        step(1'b0, '0, 1'b1, 1'b0);
        // Asynchronous reset in mid-cycle with packets queued.
        step(1'b1, rnd96(), 1'b0, 1'b0);
        step(1'b1, rnd96(), 1'b0, 1'b0);
        v_i = 1'b0; p_i = 1'b0; f_i = 1'b0; d_i = '0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            ovf[i] = 1'b0;
            unf[i] = 1'b0;
        end
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, rnd96(), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
